// File: rtl/bcd_score_counter.sv
// Multi-digit registered BCD score counter with ripple carry, wrap/saturate mode,
// synchronous new-game clear and a best-score register updated on commit.
module bcd_score_counter #(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  inc_i,
    input  logic                  clear_i,
    input  logic                  commit_i,
    output logic [4*DIGITS-1:0]   score_o,
    output logic [4*DIGITS-1:0]   best_o,
    output logic                  overflow_o,
    output logic                  new_best_o
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] score_q, score_d;
    logic [W-1:0] best_q, best_d;
    logic         overflow_q, overflow_d;
    logic         newBest_q, newBest_d;

    logic [W-1:0] incScore;
    logic         carry;
    logic         allNines;

    // Ripple-carry decimal increment: a digit advances only while every lower digit is 9.
    always_comb begin
        incScore = score_q;
        carry    = 1'b1;
        allNines = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (score_q[4*k +: 4] != 4'd9) begin
                allNines = 1'b0;
            end
            if (carry) begin
                if (score_q[4*k +: 4] == 4'd9) begin
                    incScore[4*k +: 4] = 4'd0;
                end else begin
                    incScore[4*k +: 4] = score_q[4*k +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        score_d    = score_q;
        best_d     = best_q;
        overflow_d = 1'b0;
        newBest_d  = 1'b0;

        // Best compares against the score held before this edge's clear/increment.
        if (commit_i && (score_q > best_q)) begin
            best_d    = score_q;
            newBest_d = 1'b1;
        end

        if (clear_i) begin
            score_d = '0;
        end else if (inc_i) begin
            if (allNines) begin
                overflow_d = 1'b1;
                score_d    = SATURATE ? score_q : '0;
            end else begin
                score_d = incScore;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            score_q    <= '0;
            best_q     <= '0;
            overflow_q <= 1'b0;
            newBest_q  <= 1'b0;
        end else begin
            score_q    <= score_d;
            best_q     <= best_d;
            overflow_q <= overflow_d;
            newBest_q  <= newBest_d;
        end
    end

    assign score_o    = score_q;
    assign best_o     = best_q;
    assign overflow_o = overflow_q;
    assign new_best_o = newBest_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: a wrapping and a saturating instance share
// stimulus; a decimal integer model pushes expected outputs that are popped after each edge.
module tb_bcd_score_counter;

    logic        clk;
    logic        reset;
    logic        inc;
    logic        clear;
    logic        commit;
    logic [11:0] scoreW, bestW, scoreS, bestS;
    logic        ovfW, nbW, ovfS, nbS;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct packed {
        logic [11:0] score;
        logic [11:0] best;
        logic        ovf;
        logic        nb;
    } expT;

    expT expQW[$];
    expT expQS[$];

    int modelScore[2];
    int modelBest[2];

    bcd_score_counter #(.DIGITS(3), .SATURATE(1'b0)) dutWrap (
        .clk_i(clk), .reset_i(reset), .inc_i(inc), .clear_i(clear), .commit_i(commit),
        .score_o(scoreW), .best_o(bestW), .overflow_o(ovfW), .new_best_o(nbW)
    );

    bcd_score_counter #(.DIGITS(3), .SATURATE(1'b1)) dutSat (
        .clk_i(clk), .reset_i(reset), .inc_i(inc), .clear_i(clear), .commit_i(commit),
        .score_o(scoreS), .best_o(bestS), .overflow_o(ovfS), .new_best_o(nbS)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still reports.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [11:0] toBcd(input int v);
        return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%03h expected 0x%03h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the decimal model by one edge for both modes and push the expectations.
    task automatic applyStimulus(input logic i, input logic c, input logic m);
        expT e;
        inc    = i;
        clear  = c;
        commit = m;
        for (int md = 0; md < 2; md++) begin
            int pre;
            pre     = modelScore[md];
            e.ovf   = 1'b0;
            e.nb    = 1'b0;
            if (m && pre > modelBest[md]) begin
                modelBest[md] = pre;
                e.nb          = 1'b1;
            end
            if (c) begin
                modelScore[md] = 0;
            end else if (i) begin
                if (pre == 999) begin
                    e.ovf          = 1'b1;
                    modelScore[md] = (md == 1) ? 999 : 0;
                end else begin
                    modelScore[md] = pre + 1;
                end
            end
            e.score = toBcd(modelScore[md]);
            e.best  = toBcd(modelBest[md]);
            if (md == 0) expQW.push_back(e);
            else         expQS.push_back(e);
        end
    endtask

    task automatic popCompare();
        expT w, s;
        if (expQW.size() == 0 || expQS.size() == 0) begin
            checkOutput("queue_empty", 12'd1, 12'd0);
            return;
        end
        w = expQW.pop_front();
        s = expQS.pop_front();
        checkOutput("wrap_score", scoreW, w.score);
        checkOutput("wrap_best", bestW, w.best);
        checkOutput("wrap_overflow", 12'(ovfW), 12'(w.ovf));
        checkOutput("wrap_new_best", 12'(nbW), 12'(w.nb));
        checkOutput("sat_score", scoreS, s.score);
        checkOutput("sat_best", bestS, s.best);
        checkOutput("sat_overflow", 12'(ovfS), 12'(s.ovf));
        checkOutput("sat_new_best", 12'(nbS), 12'(s.nb));
    endtask

    task automatic stepCycle(input logic i, input logic c, input logic m);
        applyStimulus(i, c, m);
        @(posedge clk);
        #1;
        popCompare();
    endtask

    task automatic incN(input int n);
        for (int k = 0; k < n; k++) stepCycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        inc    = 1'b0;
        clear  = 1'b0;
        commit = 1'b0;
        reset  = 1'b1;
        for (int md = 0; md < 2; md++) begin
            modelScore[md] = 0;
            modelBest[md]  = 0;
        end
        expQW.delete();
        expQS.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_score", scoreW, 12'h000);
        checkOutput("reset_best", bestS, 12'h000);
        checkOutput("reset_overflow", 12'(ovfW | ovfS), 12'h000);
        checkOutput("reset_new_best", 12'(nbW | nbS), 12'h000);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        inc    = 1'b0;
        clear  = 1'b0;
        commit = 1'b0;
        doReset();

        // Plain counting, then double and single carries.
        incN(12);
        checkOutput("count_12", scoreW, 12'h012);
        incN(87);
        stepCycle(1'b1, 1'b0, 1'b0);
        checkOutput("carry_099_100", scoreW, 12'h100);
        incN(9);
        stepCycle(1'b1, 1'b0, 1'b0);
        checkOutput("carry_109_110", scoreW, 12'h110);

        // Run up to all-9s and attempt one more point.
        incN(889);
        checkOutput("at_999", scoreS, 12'h999);
        stepCycle(1'b1, 1'b0, 1'b0);
        checkOutput("wrap_to_000", scoreW, 12'h000);
        checkOutput("sat_hold_999", scoreS, 12'h999);
        stepCycle(1'b0, 1'b0, 1'b0);

        // Commit with simultaneous increment, then equal-score commit.
        doReset();
        incN(30);
        stepCycle(1'b0, 1'b0, 1'b1);
        incN(12);
        stepCycle(1'b1, 1'b0, 1'b1);
        checkOutput("commit_inc_best", bestW, 12'h042);
        checkOutput("commit_inc_score", scoreW, 12'h043);
        stepCycle(1'b0, 1'b1, 1'b0);
        incN(42);
        stepCycle(1'b0, 1'b0, 1'b1);
        checkOutput("commit_equal_nb", 12'(nbW), 12'h000);
        stepCycle(1'b0, 1'b0, 1'b1);

        // clear + inc + commit together.
        stepCycle(1'b0, 1'b1, 1'b0);
        incN(57);
        stepCycle(1'b1, 1'b1, 1'b1);
        checkOutput("cic_score", scoreW, 12'h000);
        checkOutput("cic_best", bestW, 12'h057);

        // Async reset in the middle of an increment stream.
        stepCycle(1'b0, 1'b1, 1'b0);
        incN(200);
        stepCycle(1'b0, 1'b0, 1'b1);
        stepCycle(1'b0, 1'b1, 1'b0);
        incN(123);
        checkOutput("pre_reset_best", bestW, 12'h200);
        inc = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_score", scoreW, 12'h000);
        checkOutput("async_best", bestW, 12'h000);
        checkOutput("async_sat_score", scoreS, 12'h000);
        checkOutput("async_pulses", 12'(ovfW | nbW | ovfS | nbS), 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int md = 0; md < 2; md++) begin
            modelScore[md] = 0;
            modelBest[md]  = 0;
        end
        stepCycle(1'b1, 1'b0, 1'b0);
        checkOutput("after_release", scoreW, 12'h001);
        stepCycle(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
